// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl
//   Sequences one spiking-network inference of NUM_STEPS timesteps through an
//   external layer stack. It takes one input spike frame per timestep, pulses
//   the stack once per timestep and accumulates output spikes per class. It
//   then reports the class with the most spikes (ties go to the lowest index)
//   over a result handshake.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input frame handshake, in_spike carries the frame
//   stack_spike       registered frame presented to the layer stack
//   stack_clear       1-cycle pulse, clear membrane potentials
//   stack_step        1-cycle pulse, advance the stack one timestep
//   stack_out         stack output spikes, qualified by stack_valid
//   result_valid/_ready, result_class, result_count   result handshake
//   err_timeout       sticky, a step got no stack_valid in time
//   err_unexpected    sticky, stack_valid arrived while no step was pending
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | leaving reset, go to CLEAR next cycle
// CLEAR  | stack_clear pulse, zero step and class counters
// FETCH  | in_ready=1, wait for the next input frame
// ISSUE  | stack_step pulse, stack_valid already sampled here
// WAIT   | wait for stack_valid or the timeout
// ARGMAX | scan one class per cycle for the largest count
// DONE   | result_valid=1, hold the result until result_ready
module snn_inference_ctrl #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int NUM_STEPS = 16,
  parameter int TIMEOUT   = 64,
  localparam int CNT_W = $clog2(NUM_STEPS + 1),
  localparam int CLS_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_spike,
  output logic [IN_WIDTH-1:0]  stack_spike,
  output logic                 stack_clear,
  output logic                 stack_step,
  input  logic [OUT_WIDTH-1:0] stack_out,
  input  logic                 stack_valid,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CLS_W-1:0]     result_class,
  output logic [CNT_W-1:0]     result_count,
  output logic                 err_timeout,
  output logic                 err_unexpected
);

  // The timeout counter never needs to hold more than TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(NUM_STEPS - 1);
  localparam logic [CLS_W-1:0] CLS_LAST  = CLS_W'(OUT_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 step;
  logic [OUT_WIDTH-1:0][CNT_W-1:0]  cnt;
  logic [TMO_W-1:0]                 tmo;
  logic [CLS_W-1:0]                 scan;
  logic                             step_pending;
  logic                             step_done;

  assign stack_clear  = (state == S_CLEAR);
  assign stack_step   = (state == S_ISSUE);
  assign in_ready     = (state == S_FETCH);
  assign result_valid = (state == S_DONE);

  // A step ends on the stack's answer or on the timeout; the answer wins if
  // both coincide.
  assign step_pending = (state == S_ISSUE) || (state == S_WAIT);
  assign step_done    = step_pending && (stack_valid || (tmo == TMO_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      step           <= '0;
      cnt            <= '0;
      tmo            <= '0;
      scan           <= '0;
      stack_spike    <= '0;
      result_class   <= '0;
      result_count   <= '0;
      err_timeout    <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (stack_valid && !step_pending) begin
        err_unexpected <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          state <= S_CLEAR;
        end

        S_CLEAR: begin
          step  <= '0;
          cnt   <= '0;
          state <= S_FETCH;
        end

        S_FETCH: begin
          if (in_valid) begin
            stack_spike <= in_spike;
            tmo         <= '0;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE, S_WAIT: begin
          state <= S_WAIT;
          if (stack_valid) begin
            for (int i = 0; i < OUT_WIDTH; i++) begin
              cnt[i] <= cnt[i] + CNT_W'(stack_out[i]);
            end
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            // Missing answer counts as a step with no output spikes.
            err_timeout <= 1'b1;
            tmo         <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end

          if (step_done) begin
            if (step == STEP_LAST) begin
              scan         <= '0;
              result_class <= '0;
              result_count <= '0;
              state        <= S_ARGMAX;
            end else begin
              step  <= step + 1'b1;
              state <= S_FETCH;
            end
          end
        end

        S_ARGMAX: begin
          // Strictly greater keeps the lowest index on ties.
          if (cnt[scan] > result_count) begin
            result_class <= scan;
            result_count <= cnt[scan];
          end
          if (scan == CLS_LAST) begin
            state <= S_DONE;
          end else begin
            scan <= scan + 1'b1;
          end
        end

        S_DONE: begin
          if (result_ready) begin
            state <= S_CLEAR;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
module tb_snn_inference_ctrl;

  localparam int IW = 8;
  localparam int OW = 8;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam int CW = $clog2(NS + 1);
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_spike = '0;
  logic [IW-1:0] stack_spike;
  logic          stack_clear;
  logic          stack_step;
  logic [OW-1:0] stack_out = '0;
  logic          stack_valid = 1'b0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [LW-1:0] result_class;
  logic [CW-1:0] result_count;
  logic          err_timeout;
  logic          err_unexpected;

  snn_inference_ctrl #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .NUM_STEPS(NS),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_spike      (in_spike),
    .stack_spike   (stack_spike),
    .stack_clear   (stack_clear),
    .stack_step    (stack_step),
    .stack_out     (stack_out),
    .stack_valid   (stack_valid),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_class  (result_class),
    .result_count  (result_count),
    .err_timeout   (err_timeout),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected sticky flags and the per-run stimulus: the stack answer for each
  // step and its delay in cycles after the step pulse (negative = silent).
  bit            exp_tmo = 1'b0;
  bit            exp_unx = 1'b0;
  logic [OW-1:0] resp_q [NS];
  int            dly_q  [NS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count spikes of every answered step per class, then pick the
  // class with the largest total, lowest index on ties.
  task automatic model(output int cls, output int count);
    int counts [OW];
    for (int c = 0; c < OW; c++) counts[c] = 0;
    for (int s = 0; s < NS; s++) begin
      if (dly_q[s] >= 0) begin
        for (int c = 0; c < OW; c++) counts[c] += int'(resp_q[s][c]);
      end
    end
    cls = 0;
    for (int c = 1; c < OW; c++) begin
      if (counts[c] > counts[cls]) cls = c;
    end
    count = counts[cls];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},     32'(in_ready),       32'd0);
    chk({tag, "_stack_spike"},  32'(stack_spike),    32'd0);
    chk({tag, "_stack_clear"},  32'(stack_clear),    32'd0);
    chk({tag, "_stack_step"},   32'(stack_step),     32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid),   32'd0);
    chk({tag, "_result_class"}, 32'(result_class),   32'd0);
    chk({tag, "_result_count"}, 32'(result_count),   32'd0);
    chk({tag, "_err_timeout"},  32'(err_timeout),    32'd0);
    chk({tag, "_err_unexp"},    32'(err_unexpected), 32'd0);
  endtask

  // Release mid-cycle: one more IDLE cycle, then CLEAR, then FETCH.
  task automatic release_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_clear", 32'(stack_clear), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("clear_cycle", 32'(stack_clear), 32'd1);
    chk("clear_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("fetch_cycle", 32'(in_ready), 32'd1);
    chk("clear_once", 32'(stack_clear), 32'd0);
  endtask

  task automatic run_inf(input bit late, input int abort_step, input int hold);
    logic [IW-1:0] frame;
    int w, g, n, ecls, ecnt;
    for (int s = 0; s < NS; s++) begin
      w = 0;
      while (!in_ready && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("fetch_wait", 32'(w < 10), 32'd1);
      g = int'($urandom_range(0, 2));
      repeat (g) @(negedge clk);
      chk("ready_idle", 32'(in_ready), 32'd1);
      chk("no_step_idle", 32'(stack_step), 32'd0);
      frame    = IW'($urandom);
      in_valid = 1'b1;
      in_spike = frame;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_spike = IW'($urandom);
      @(negedge clk);
      chk("step_pulse", 32'(stack_step), 32'd1);
      chk("stack_spike", 32'(stack_spike), 32'(frame));
      chk("ready_low", 32'(in_ready), 32'd0);

      if (s == abort_step) begin
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        chk_zero("abort");
        exp_tmo = 1'b0;
        exp_unx = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        return;
      end

      if (dly_q[s] < 0) begin
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("tmo_not_yet", 32'(err_timeout), 32'(exp_tmo));
        @(posedge clk); #1;
        exp_tmo = 1'b1;
      end else begin
        repeat (dly_q[s]) @(negedge clk);
        stack_valid = 1'b1;
        stack_out   = resp_q[s];
        @(posedge clk); #1;
        stack_valid = 1'b0;
        stack_out   = OW'($urandom);
      end

      if (s < NS - 1) begin
        @(negedge clk);
        chk("next_fetch", 32'(in_ready), 32'd1);
        chk("tmo_flag", 32'(err_timeout), 32'(exp_tmo));
        if (late && dly_q[s] < 0) begin
          stack_valid = 1'b1;
          stack_out   = OW'($urandom);
          @(posedge clk); #1;
          stack_valid = 1'b0;
          exp_unx     = 1'b1;
          @(negedge clk);
          chk("unexp_flag", 32'(err_unexpected), 32'd1);
          chk("unexp_ignored", 32'(in_ready), 32'd1);
        end
      end
    end

    n = 0;
    @(negedge clk);
    while (!result_valid && n < 3 * OW) begin
      @(negedge clk);
      n++;
    end
    chk("argmax_latency", 32'(n), 32'(OW));
    model(ecls, ecnt);
    chk("result_class", 32'(result_class), 32'(ecls));
    chk("result_count", 32'(result_count), 32'(ecnt));
    chk("tmo_final", 32'(err_timeout), 32'(exp_tmo));
    chk("unexp_final", 32'(err_unexpected), 32'(exp_unx));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_class", 32'(result_class), 32'(ecls));
      chk("hold_count", 32'(result_count), 32'(ecnt));
      chk("hold_no_ready", 32'(in_ready), 32'd0);
      chk("hold_no_step", 32'(stack_step), 32'd0);
    end

    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("restart_clear", 32'(stack_clear), 32'd1);
    chk("valid_dropped", 32'(result_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    release_reset();

    resp_q = '{default: 8'h04};
    dly_q  = '{default: 2};
    run_inf(1'b0, -1, 0);

    resp_q = '{8'h22, 8'h02, 8'h20, 8'h00};
    run_inf(1'b0, -1, 5);

    for (int s = 0; s < NS; s++) resp_q[s] = OW'($urandom);
    dly_q = '{7, -1, 0, 2};
    run_inf(1'b1, -1, 1);

    dly_q = '{default: 2};
    run_inf(1'b0, 2, 0);

    resp_q = '{default: 8'h80};
    for (int s = 0; s < NS; s++) dly_q[s] = int'($urandom_range(0, TO - 1));
    run_inf(1'b0, -1, 0);

    for (int r = 0; r < 15; r++) begin
      for (int s = 0; s < NS; s++) begin
        resp_q[s] = OW'($urandom & $urandom);
        dly_q[s]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      end
      run_inf((r % 3) == 0, -1, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
